video_timing_generator: RTL and testbench
=========================================

# video_timing_generator

Parametrised raster timing generator for the GPU's display output. It supersedes the fixed 640x480 VGA timing block. It generates h/v sync with configurable porches, sync widths and polarities, and a pixel clock-enable divided from the system clock. It also provides a data-enable and per-line/per-frame strobes for the framebuffer fetch logic, plus reduced-resolution pixel coordinates.

## Interface
Parameters:
- clk_freq, 50000000, system clock frequency in Hz
- pixel_freq, 25000000, pixel rate in Hz; clk_freq must be an integer multiple (DIV = clk_freq/pixel_freq, DIV >= 1)
- h_active / h_front / h_sync_len / h_back, 640/16/96/48, horizontal segment lengths in pixels
- v_active / v_front / v_sync_len / v_back, 480/10/2/33, vertical segment lengths in lines
- h_sync_pol / v_sync_pol, 0/0, level driven while the sync pulse is asserted
- bit_reduction, 0, right-shift applied to the pixel coordinates

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- h_sync  out  1  horizontal sync
- v_sync  out  1  vertical sync
- active  out  1  high inside the visible area
- h_pixel  out  $clog2(h_active)-bit_reduction  visible column >> bit_reduction
- v_pixel  out  $clog2(v_active)-bit_reduction  visible line >> bit_reduction
- pixel_tick  out  1  high for one clk on the first clk of each pixel period
- line_start  out  1  one-clk pulse at pixel (0, v) for v < v_active
- frame_start  out  1  one-clk pulse at pixel (0, 0)

## Operation
- H_TOTAL = sum of the h_* segments (default 800). V_TOTAL = sum of the v_* segments (default 525).
- Segment order on each axis: active, front porch, sync, back porch.
- div_cnt runs 0..DIV-1 and wraps.
- h_cnt advances on the edge where div_cnt == DIV-1 and wraps at H_TOTAL-1.
- v_cnt advances when h_cnt wraps and itself wraps at V_TOTAL-1.
- Decode, evaluated from the pre-edge counters:
  - active = (h_cnt < h_active) && (v_cnt < v_active)
  - h_sync asserted while h_active+h_front <= h_cnt < h_active+h_front+h_sync_len
  - v_sync asserted while v_cnt lies in the same vertical range
  - h_pixel/v_pixel = counter >> bit_reduction while active, otherwise 0
  - pixel_tick = (div_cnt == 0)
  - line_start = pixel_tick && h_cnt == 0 && v_cnt < v_active
  - frame_start = pixel_tick && h_cnt == 0 && v_cnt == 0
- All outputs are registered.
- Reset values, applied immediately on assertion:
  - counters 0
  - h_sync = !h_sync_pol, v_sync = !v_sync_pol
  - active = 0, h_pixel = v_pixel = 0
  - pixel_tick = line_start = frame_start = 0
- Elaboration error if clk_freq % pixel_freq != 0, if any segment length is 0, or if bit_reduction >= $clog2(v_active).

## Timing
- Output latency is one clk from the counter state. The first rising edge after reset release shows pixel (0,0): active=1, pixel_tick=1, line_start=1, frame_start=1.
- Each pixel lasts DIV clks. One line lasts H_TOTAL*DIV clks and one frame lasts V_TOTAL*H_TOTAL*DIV clks.
- v_sync changes only on the edge that outputs h_cnt == 0.
- With DIV=1, pixel_tick is held high continuously after the first edge.
- Reset asserted mid-frame forces reset values asynchronously. On release, timing restarts at (0,0); no partial-frame state is kept.

## Structure
- Shared package video_timing_pkg holds:
  - VGA 640x480@60 segment constants, plus 800x600 constants for reuse
  - a width helper function returning $clog2 of a total
- One sub-module, timing_axis_counter: counter, wrap, and segment decode for a single axis, with an advance input and a wrap output. It is instantiated twice, chained h -> v.
- The divider and the output registers stay in the top module.

## Test plan
- Defaults, release reset: first edge gives active=1, frame_start=1, h_pixel=0, v_pixel=0. frame_start period is 840000 clks; line_start period is 1600 clks during visible lines.
- Defaults: h_sync goes low 1312 clks after line_start, stays low 192 clks, then returns high. active is low from clk 1280 to clk 1599 of every line.
- Defaults: v_sync goes low at the start of line 490 for exactly 3200 clks. active stays 0 throughout lines 480-524.
- bit_reduction=3: h_pixel increments every 16 clks and reaches a maximum of 79. v_pixel reaches a maximum of 59. Both read 0 in blanking.
- DIV=1 with h 8/1/2/1, v 4/1/1/1, and both polarities 1:
  - pixel_tick is constantly 1
  - h_sync idles at 0 and is 1 for exactly 2 clks per 12-clk line
  - frame period is 84 clks
- Defaults, reset asserted during line 200 then released: outputs return to reset values within the same clk. The first edge after release shows frame_start=1 and v_pixel=0.

Source files
------------

// File: rtl/video_timing_pkg.sv
// Shared raster constants and sizing helpers for the video timing generator.
package video_timing_pkg;

    localparam int VGA_H_ACTIVE   = 640;
    localparam int VGA_H_FRONT    = 16;
    localparam int VGA_H_SYNC     = 96;
    localparam int VGA_H_BACK     = 48;
    localparam int VGA_V_ACTIVE   = 480;
    localparam int VGA_V_FRONT    = 10;
    localparam int VGA_V_SYNC     = 2;
    localparam int VGA_V_BACK     = 33;

    localparam int SVGA_H_ACTIVE  = 800;
    localparam int SVGA_H_FRONT   = 40;
    localparam int SVGA_H_SYNC    = 128;
    localparam int SVGA_H_BACK    = 88;
    localparam int SVGA_V_ACTIVE  = 600;
    localparam int SVGA_V_FRONT   = 1;
    localparam int SVGA_V_SYNC    = 4;
    localparam int SVGA_V_BACK    = 23;

    // A total of 1 still needs a one-bit counter.
    function automatic int cnt_width(input int total);
        return (total > 1) ? $clog2(total) : 1;
    endfunction

endpackage

// File: rtl/timing_axis_counter.sv
// One raster axis: position counter with wrap, plus active and sync-window decode.
module timing_axis_counter
    import video_timing_pkg::*;
#(
    parameter int total      = 800,
    parameter int active_len = 640,
    parameter int sync_start = 656,
    parameter int sync_len   = 96,
    parameter int width      = cnt_width(total)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             advance,
    output logic [width-1:0] cnt,
    output logic             wrap,
    output logic             in_active,
    output logic             in_sync
);

    assign wrap = advance && (cnt == width'(total - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (advance) begin
            cnt <= wrap ? '0 : cnt + width'(1);
        end
    end

    assign in_active = (cnt < width'(active_len));
    assign in_sync   = (cnt >= width'(sync_start)) && (cnt < width'(sync_start + sync_len));

endmodule

// File: rtl/video_timing_generator.sv
// Parametrised raster timing: pixel divider, chained h/v axis counters, registered outputs.
module video_timing_generator
    import video_timing_pkg::*;
#(
    parameter int clk_freq      = 50000000,
    parameter int pixel_freq    = 25000000,
    parameter int h_active      = VGA_H_ACTIVE,
    parameter int h_front       = VGA_H_FRONT,
    parameter int h_sync_len    = VGA_H_SYNC,
    parameter int h_back        = VGA_H_BACK,
    parameter int v_active      = VGA_V_ACTIVE,
    parameter int v_front       = VGA_V_FRONT,
    parameter int v_sync_len    = VGA_V_SYNC,
    parameter int v_back        = VGA_V_BACK,
    parameter bit h_sync_pol    = 1'b0,
    parameter bit v_sync_pol    = 1'b0,
    parameter int bit_reduction = 0
) (
    input  logic                                      clk,
    input  logic                                      reset,
    output logic                                      h_sync,
    output logic                                      v_sync,
    output logic                                      active,
    output logic [$clog2(h_active)-bit_reduction-1:0] h_pixel,
    output logic [$clog2(v_active)-bit_reduction-1:0] v_pixel,
    output logic                                      pixel_tick,
    output logic                                      line_start,
    output logic                                      frame_start
);

    localparam int DIV     = (pixel_freq > 0) ? clk_freq / pixel_freq : 1;
    localparam int H_TOTAL = h_active + h_front + h_sync_len + h_back;
    localparam int V_TOTAL = v_active + v_front + v_sync_len + v_back;
    localparam int DW      = cnt_width(DIV);
    localparam int HW      = cnt_width(H_TOTAL);
    localparam int VW      = cnt_width(V_TOTAL);
    localparam int HPW     = $clog2(h_active) - bit_reduction;
    localparam int VPW     = $clog2(v_active) - bit_reduction;

    if ((pixel_freq <= 0) || (clk_freq % pixel_freq != 0) || (DIV < 1) ||
        (h_active <= 0) || (h_front <= 0) || (h_sync_len <= 0) || (h_back <= 0) ||
        (v_active <= 0) || (v_front <= 0) || (v_sync_len <= 0) || (v_back <= 0) ||
        (bit_reduction < 0) || (bit_reduction >= $clog2(v_active)) ||
        (bit_reduction >= $clog2(h_active))) begin : g_param_check
        $error("video_timing_generator: illegal parameter set");
    end

    logic [DW-1:0] div_cnt;
    logic          pixel_adv;
    logic [HW-1:0] h_cnt;
    logic [VW-1:0] v_cnt;
    logic          h_wrap;
    logic          v_wrap_unused;
    logic          h_in_active, h_in_sync;
    logic          v_in_active, v_in_sync;

    assign pixel_adv = (div_cnt == DW'(DIV - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            div_cnt <= '0;
        end else if (pixel_adv) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + DW'(1);
        end
    end

    timing_axis_counter #(
        .total      (H_TOTAL),
        .active_len (h_active),
        .sync_start (h_active + h_front),
        .sync_len   (h_sync_len),
        .width      (HW)
    ) u_h_axis (
        .clk       (clk),
        .reset     (reset),
        .advance   (pixel_adv),
        .cnt       (h_cnt),
        .wrap      (h_wrap),
        .in_active (h_in_active),
        .in_sync   (h_in_sync)
    );

    timing_axis_counter #(
        .total      (V_TOTAL),
        .active_len (v_active),
        .sync_start (v_active + v_front),
        .sync_len   (v_sync_len),
        .width      (VW)
    ) u_v_axis (
        .clk       (clk),
        .reset     (reset),
        .advance   (h_wrap),
        .cnt       (v_cnt),
        .wrap      (v_wrap_unused),
        .in_active (v_in_active),
        .in_sync   (v_in_sync)
    );

    // Decode from the pre-edge counters; the output registers add the single clk of latency.
    logic active_next, pixel_tick_next, line_start_next, frame_start_next;

    assign active_next      = h_in_active && v_in_active;
    assign pixel_tick_next  = (div_cnt == '0);
    assign line_start_next  = pixel_tick_next && (h_cnt == '0) && v_in_active;
    assign frame_start_next = pixel_tick_next && (h_cnt == '0) && (v_cnt == '0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            h_sync      <= ~h_sync_pol;
            v_sync      <= ~v_sync_pol;
            active      <= 1'b0;
            h_pixel     <= '0;
            v_pixel     <= '0;
            pixel_tick  <= 1'b0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            h_sync      <= h_in_sync ? h_sync_pol : ~h_sync_pol;
            v_sync      <= v_in_sync ? v_sync_pol : ~v_sync_pol;
            active      <= active_next;
            h_pixel     <= active_next ? HPW'(h_cnt >> bit_reduction) : '0;
            v_pixel     <= active_next ? VPW'(v_cnt >> bit_reduction) : '0;
            pixel_tick  <= pixel_tick_next;
            line_start  <= line_start_next;
            frame_start <= frame_start_next;
        end
    end

endmodule

// File: tb/tb_video_timing_generator.sv
// Directed bench for video_timing_generator over four parameter sets sharing one clock.
module tb_video_timing_generator;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Defaults: 640x480, DIV=2
    logic       d_rst = 1'b0;
    logic       d_hs, d_vs, d_act, d_pt, d_ls, d_fs;
    logic [9:0] d_hp;
    logic [8:0] d_vp;

    video_timing_generator dut_def (
        .clk(clk), .reset(d_rst), .h_sync(d_hs), .v_sync(d_vs), .active(d_act),
        .h_pixel(d_hp), .v_pixel(d_vp), .pixel_tick(d_pt), .line_start(d_ls), .frame_start(d_fs)
    );

    // Defaults with bit_reduction=3
    logic       b_rst = 1'b0;
    logic       b_hs, b_vs, b_act, b_pt, b_ls, b_fs;
    logic [6:0] b_hp;
    logic [5:0] b_vp;

    video_timing_generator #(.bit_reduction(3)) dut_br (
        .clk(clk), .reset(b_rst), .h_sync(b_hs), .v_sync(b_vs), .active(b_act),
        .h_pixel(b_hp), .v_pixel(b_vp), .pixel_tick(b_pt), .line_start(b_ls), .frame_start(b_fs)
    );

    // Small raster, DIV=2: h 16/2/4/2 (24), v 8/2/3/2 (15), frame 720 clks
    logic       m_rst = 1'b0;
    logic       m_hs, m_vs, m_act, m_pt, m_ls, m_fs;
    logic [3:0] m_hp;
    logic [2:0] m_vp;

    video_timing_generator #(
        .h_active(16), .h_front(2), .h_sync_len(4), .h_back(2),
        .v_active(8), .v_front(2), .v_sync_len(3), .v_back(2)
    ) dut_mid (
        .clk(clk), .reset(m_rst), .h_sync(m_hs), .v_sync(m_vs), .active(m_act),
        .h_pixel(m_hp), .v_pixel(m_vp), .pixel_tick(m_pt), .line_start(m_ls), .frame_start(m_fs)
    );

    // DIV=1, h 8/1/2/1 (12), v 4/1/1/1 (7), positive syncs
    logic       s_rst = 1'b0;
    logic       s_hs, s_vs, s_act, s_pt, s_ls, s_fs;
    logic [2:0] s_hp;
    logic [1:0] s_vp;

    video_timing_generator #(
        .clk_freq(25000000), .pixel_freq(25000000),
        .h_active(8), .h_front(1), .h_sync_len(2), .h_back(1),
        .v_active(4), .v_front(1), .v_sync_len(1), .v_back(1),
        .h_sync_pol(1'b1), .v_sync_pol(1'b1)
    ) dut_small (
        .clk(clk), .reset(s_rst), .h_sync(s_hs), .v_sync(s_vs), .active(s_act),
        .h_pixel(s_hp), .v_pixel(s_vp), .pixel_tick(s_pt), .line_start(s_ls), .frame_start(s_fs)
    );

    task automatic test_reset();
        @(negedge clk);
        d_rst = 1'b0;
        #1;
        tests++;
        if ({d_hs, d_vs, d_act, d_pt, d_ls, d_fs} !== 6'b110000) begin
            fails++;
            $display("FAIL reset_flags got=%b exp=110000", {d_hs, d_vs, d_act, d_pt, d_ls, d_fs});
        end
        tests++;
        if (d_hp !== 10'd0 || d_vp !== 9'd0) begin
            fails++;
            $display("FAIL reset_pixels got h=%0d v=%0d exp h=0 v=0", d_hp, d_vp);
        end
        tests++;
        if ({s_hs, s_vs} !== 2'b00) begin
            fails++;
            $display("FAIL reset_pos_polarity got=%b exp=00", {s_hs, s_vs});
        end
        @(negedge clk);
        d_rst = 1'b1;
        @(posedge clk);
        #1;
        tests++;
        if ({d_act, d_pt, d_ls, d_fs} !== 4'b1111) begin
            fails++;
            $display("FAIL first_edge_flags got=%b exp=1111", {d_act, d_pt, d_ls, d_fs});
        end
        tests++;
        if (d_hp !== 10'd0 || d_vp !== 9'd0) begin
            fails++;
            $display("FAIL first_edge_pixels got h=%0d v=%0d exp h=0 v=0", d_hp, d_vp);
        end
        $display("[TB] test_reset done");
    endtask

    task automatic test_default_lines();
        int x;
        logic e_act, e_hs, e_pt, e_ls, e_fs;
        logic [9:0] e_hp;
        logic [8:0] e_vp;
        logic [24:0] got, exp;
        @(negedge clk); d_rst = 1'b0;
        @(negedge clk); d_rst = 1'b1;
        for (int c = 0; c < 3200; c++) begin
            @(posedge clk);
            #1;
            x     = c % 1600;
            e_act = (x < 1280);
            e_hs  = !((x >= 1312) && (x < 1504));
            e_pt  = (c % 2 == 0);
            e_ls  = (x == 0);
            e_fs  = (c == 0);
            e_hp  = e_act ? 10'(x / 2) : 10'd0;
            e_vp  = e_act ? 9'(c / 1600) : 9'd0;
            got = {d_act, d_hs, d_vs, d_pt, d_ls, d_fs, d_hp, d_vp};
            exp = {e_act, e_hs, 1'b1, e_pt, e_ls, e_fs, e_hp, e_vp};
            tests++;
            if (got !== exp) begin
                fails++;
                $display("FAIL default_line clk=%0d got=%b exp=%b", c, got, exp);
                break;
            end
        end
        $display("[TB] test_default_lines done");
    endtask

    task automatic test_bit_reduction();
        int x;
        int line;
        int max_hp;
        logic e_act;
        logic [6:0] e_hp;
        logic [5:0] e_vp;
        logic [13:0] got, exp;
        max_hp = 0;
        @(negedge clk); b_rst = 1'b0;
        @(negedge clk); b_rst = 1'b1;
        for (int c = 0; c < 14400; c++) begin
            @(posedge clk);
            #1;
            x     = c % 1600;
            line  = c / 1600;
            e_act = (x < 1280);
            e_hp  = e_act ? 7'((x / 2) >> 3) : 7'd0;
            e_vp  = e_act ? 6'(line >> 3) : 6'd0;
            if (int'(b_hp) > max_hp) max_hp = int'(b_hp);
            got = {b_act, b_hp, b_vp};
            exp = {e_act, e_hp, e_vp};
            tests++;
            if (got !== exp) begin
                fails++;
                $display("FAIL bit_reduction clk=%0d got=%b exp=%b", c, got, exp);
                break;
            end
        end
        tests++;
        if (max_hp !== 79) begin
            fails++;
            $display("FAIL bit_reduction_max_h got=%0d exp=79", max_hp);
        end
        $display("[TB] test_bit_reduction done");
    endtask

    task automatic test_vsync_frames();
        int hpos;
        int line;
        logic e_act, e_hs, e_vs, e_pt, e_ls, e_fs;
        logic [3:0] e_hp;
        logic [2:0] e_vp;
        logic [12:0] got, exp;
        @(negedge clk); m_rst = 1'b0;
        @(negedge clk); m_rst = 1'b1;
        for (int c = 0; c < 1440; c++) begin
            @(posedge clk);
            #1;
            hpos  = (c % 48) / 2;
            line  = (c / 48) % 15;
            e_act = (hpos < 16) && (line < 8);
            e_hs  = !((hpos >= 18) && (hpos < 22));
            e_vs  = !((line >= 10) && (line < 13));
            e_pt  = (c % 2 == 0);
            e_ls  = (c % 48 == 0) && (line < 8);
            e_fs  = (c % 720 == 0);
            e_hp  = e_act ? 4'(hpos) : 4'd0;
            e_vp  = e_act ? 3'(line) : 3'd0;
            got = {m_act, m_hs, m_vs, m_pt, m_ls, m_fs, m_hp, m_vp};
            exp = {e_act, e_hs, e_vs, e_pt, e_ls, e_fs, e_hp, e_vp};
            tests++;
            if (got !== exp) begin
                fails++;
                $display("FAIL vsync_frame clk=%0d got=%b exp=%b", c, got, exp);
                break;
            end
        end
        $display("[TB] test_vsync_frames done");
    endtask

    task automatic test_div1();
        int hpos;
        int line;
        logic e_act, e_hs, e_vs, e_ls, e_fs;
        logic [2:0] e_hp;
        logic [1:0] e_vp;
        logic [10:0] got, exp;
        @(negedge clk); s_rst = 1'b0;
        @(negedge clk); s_rst = 1'b1;
        for (int c = 0; c < 168; c++) begin
            @(posedge clk);
            #1;
            hpos  = c % 12;
            line  = (c / 12) % 7;
            e_act = (hpos < 8) && (line < 4);
            e_hs  = (hpos >= 9) && (hpos < 11);
            e_vs  = (line == 5);
            e_ls  = (hpos == 0) && (line < 4);
            e_fs  = (c % 84 == 0);
            e_hp  = e_act ? 3'(hpos) : 3'd0;
            e_vp  = e_act ? 2'(line) : 2'd0;
            got = {s_act, s_hs, s_vs, s_pt, s_ls, s_fs, s_hp, s_vp};
            exp = {e_act, e_hs, e_vs, 1'b1, e_ls, e_fs, e_hp, e_vp};
            tests++;
            if (got !== exp) begin
                fails++;
                $display("FAIL div1 clk=%0d got=%b exp=%b", c, got, exp);
                break;
            end
        end
        $display("[TB] test_div1 done");
    endtask

    task automatic test_reset_mid_frame();
        @(negedge clk); d_rst = 1'b0;
        @(negedge clk); d_rst = 1'b1;
        repeat (3300) @(posedge clk);
        #1;
        tests++;
        if (d_vp !== 9'd2) begin
            fails++;
            $display("FAIL pre_reset_line got=%0d exp=2", d_vp);
        end
        @(negedge clk);
        d_rst = 1'b0;
        #1;
        tests++;
        if ({d_hs, d_vs, d_act, d_pt, d_ls, d_fs} !== 6'b110000 || d_hp !== 10'd0 || d_vp !== 9'd0) begin
            fails++;
            $display("FAIL mid_reset_async got=%b h=%0d v=%0d exp=110000 h=0 v=0",
                     {d_hs, d_vs, d_act, d_pt, d_ls, d_fs}, d_hp, d_vp);
        end
        repeat (2) @(negedge clk);
        tests++;
        if ({d_act, d_pt, d_fs} !== 3'b000) begin
            fails++;
            $display("FAIL mid_reset_held got=%b exp=000", {d_act, d_pt, d_fs});
        end
        d_rst = 1'b1;
        @(posedge clk);
        #1;
        tests++;
        if ({d_act, d_ls, d_fs} !== 3'b111 || d_vp !== 9'd0 || d_hp !== 10'd0) begin
            fails++;
            $display("FAIL restart_frame got=%b h=%0d v=%0d exp=111 h=0 v=0",
                     {d_act, d_ls, d_fs}, d_hp, d_vp);
        end
        repeat (2) @(posedge clk);
        #1;
        tests++;
        if (d_hp !== 10'd1 || d_pt !== 1'b1) begin
            fails++;
            $display("FAIL restart_advance got h=%0d tick=%b exp h=1 tick=1", d_hp, d_pt);
        end
        $display("[TB] test_reset_mid_frame done");
    endtask

    initial begin
        test_reset();
        test_default_lines();
        test_bit_reduction();
        test_vsync_frames();
        test_div1();
        test_reset_mid_frame();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
